// File: rtl/atari_input_pkg.sv
// Shared types and constants for the Atari 2600 paddle/mouse input path.
package atari_input_pkg;

  typedef enum logic {
    SRC_JOY   = 1'b0,
    SRC_MOUSE = 1'b1
  } src_mode_t;

  localparam int STEP_LIMIT_DEF = 10;
  localparam int POS_MAX_DEF    = 127;

  // ps2_mouse field positions
  localparam int PS2_STB     = 24;
  localparam int PS2_YSGN    = 5;
  localparam int PS2_XSGN    = 4;
  localparam int PS2_BTN_LO  = 0;
  localparam int PS2_XMOV_LO = 8;
  localparam int PS2_YMOV_LO = 16;

endpackage

// File: rtl/paddle_mouse_emu_if.sv
// Bundle between hps_io-side sources and the A2601 paddle/button inputs.
interface paddle_mouse_emu_if;
  logic [24:0] ps2_mouse;
  logic [15:0] joya_0;
  logic [15:0] joy_0;
  logic [7:0]  ax;
  logic [7:0]  ay;
  logic [7:0]  j0;
  logic        mouse_mode;

  modport master (
    output ps2_mouse, joya_0, joy_0,
    input  ax, ay, j0, mouse_mode
  );

  modport slave (
    input  ps2_mouse, joya_0, joy_0,
    output ax, ay, j0, mouse_mode
  );
endinterface

// File: rtl/paddle_mouse_emu_sat_accum.sv
// One axis: clamp a raw packet delta (stage 1), then add it into a
// saturating position register (stage 2). clr_i overrides any pending add.
module sat_accum
  import atari_input_pkg::*;
#(
  parameter int STEP_LIMIT = STEP_LIMIT_DEF,
  parameter int POS_MAX    = POS_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              in_valid_i,
  input  logic signed [8:0] raw_i,
  output logic signed [8:0] pos_o,
  output logic              step_valid_o
);

  localparam logic signed [8:0] LIM_HI = 9'(STEP_LIMIT);
  localparam logic signed [8:0] LIM_LO = 9'(-STEP_LIMIT);
  localparam logic signed [9:0] POS_HI = 10'(POS_MAX);
  localparam logic signed [9:0] POS_LO = 10'(-(POS_MAX + 1));

  logic signed [8:0] step_q, step_d;
  logic              v_q, v_d;
  logic signed [8:0] pos_q, pos_d;
  logic signed [9:0] sum;

  // Step clamp on accept, then saturating add on the following cycle.
  always_comb begin
    v_d    = in_valid_i;
    step_d = step_q;
    if (in_valid_i) begin
      if (raw_i > LIM_HI)      step_d = LIM_HI;
      else if (raw_i < LIM_LO) step_d = LIM_LO;
      else                     step_d = raw_i;
    end
    sum   = {pos_q[8], pos_q} + {step_q[8], step_q};
    pos_d = pos_q;
    if (clr_i) begin
      pos_d = '0;
    end else if (v_q) begin
      if (sum > POS_HI)      pos_d = POS_HI[8:0];
      else if (sum < POS_LO) pos_d = POS_LO[8:0];
      else                   pos_d = sum[8:0];
    end
  end

  // Pipeline and accumulator registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q <= '0;
      v_q    <= 1'b0;
      pos_q  <= '0;
    end else begin
      step_q <= step_d;
      v_q    <= v_d;
      pos_q  <= pos_d;
    end
  end

  assign pos_o        = pos_q;
  assign step_valid_o = v_q;

endmodule

// File: rtl/paddle_mouse_emu.sv
// PS/2 mouse to absolute paddle position, with analog-stick arbitration.
module paddle_mouse_emu
  import atari_input_pkg::*;
#(
  parameter int STEP_LIMIT = STEP_LIMIT_DEF,
  parameter int POS_MAX    = POS_MAX_DEF
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  paddle_mouse_emu_if.slave  bus
);

  logic              stb_q, stb_d;
  logic [1:0]        btn_q, btn_d;
  src_mode_t         state_q, state_d;
  logic [7:0]        ax_q, ax_d, ay_q, ay_d, j0_q, j0_d;
  logic              mode_q, mode_d;
  logic              accept, joy_act, out_mouse;
  logic signed [8:0] raw_x, raw_y, mx, my;
  logic              vx, vy;
  logic              unused_ok;

  // Packet detect, delta extraction, source selection and output muxing.
  always_comb begin
    stb_d   = bus.ps2_mouse[PS2_STB];
    accept  = stb_d != stb_q;
    raw_x   = {bus.ps2_mouse[PS2_XSGN], bus.ps2_mouse[PS2_XSGN],
               bus.ps2_mouse[PS2_XMOV_LO+1 +: 7]};
    raw_y   = {bus.ps2_mouse[PS2_YSGN], bus.ps2_mouse[PS2_YSGN],
               bus.ps2_mouse[PS2_YMOV_LO+1 +: 7]};
    btn_d   = accept ? bus.ps2_mouse[PS2_BTN_LO +: 2] : btn_q;
    joy_act = |bus.joya_0;
    state_d = state_q;
    if (joy_act)  state_d = SRC_JOY;
    else if (vx)  state_d = SRC_MOUSE;
    // Entering MOUSE is keyed to the stage-2 update so that mouse_mode rises
    // with the first mouse position; the stick overrides the output
    // immediately so its path stays one cycle.
    out_mouse = (state_q == SRC_MOUSE) && !joy_act;
    if (out_mouse) begin
      ax_d = mx[7:0];
      ay_d = my[7:0];
      j0_d = {bus.joy_0[7], btn_q, bus.joy_0[4:0]};
    end else begin
      ax_d = bus.joya_0[7:0];
      ay_d = bus.joya_0[15:8];
      j0_d = bus.joy_0[7:0];
    end
    mode_d = out_mouse;
  end

  // Strobe history and button latch; strobe tracks input during reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      stb_q <= bus.ps2_mouse[PS2_STB];
      btn_q <= '0;
    end else begin
      stb_q <= stb_d;
      btn_q <= btn_d;
    end
  end

  // Source FSM and registered paddle/button outputs.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= SRC_JOY;
      ax_q    <= '0;
      ay_q    <= '0;
      j0_q    <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      j0_q    <= j0_d;
      mode_q  <= mode_d;
    end
  end

  sat_accum #(.STEP_LIMIT(STEP_LIMIT), .POS_MAX(POS_MAX)) u_acc_x (
    .clk(clk_sys), .rst_n(reset_n), .clr_i(joy_act), .in_valid_i(accept),
    .raw_i(raw_x), .pos_o(mx), .step_valid_o(vx)
  );

  sat_accum #(.STEP_LIMIT(STEP_LIMIT), .POS_MAX(POS_MAX)) u_acc_y (
    .clk(clk_sys), .rst_n(reset_n), .clr_i(joy_act), .in_valid_i(accept),
    .raw_i(raw_y), .pos_o(my), .step_valid_o(vy)
  );

  assign bus.ax         = ax_q;
  assign bus.ay         = ay_q;
  assign bus.j0         = j0_q;
  assign bus.mouse_mode = mode_q;

  assign unused_ok = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3:2],
                       bus.joy_0[15:8], bus.joy_0[6:5], mx[8], my[8], vy};

endmodule

// File: tb/tb_paddle_mouse_emu.sv
// Scoreboard bench for paddle_mouse_emu: expected outputs are queued when a
// packet is driven and compared when their latency elapses.
module tb_paddle_mouse_emu;

  typedef struct {
    int         due;
    logic [7:0] ax;
    logic [7:0] ay;
    logic [7:0] j0;
    logic       mode;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  int         mx_m, my_m;
  logic [1:0] btn_m;

  paddle_mouse_emu_if bus ();

  paddle_mouse_emu #(.STEP_LIMIT(10), .POS_MAX(127)) dut (
    .clk_sys(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int stepv(bit s, logic [7:0] mv);
    int v;
    v = s ? (int'(mv >> 1) - 128) : int'(mv >> 1);
    if (v > 10)  v = 10;
    if (v < -10) v = -10;
    return v;
  endfunction

  function automatic int satv(int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_packet(bit xs, logic [7:0] xm, bit ys, logic [7:0] ym, logic [1:0] b);
    exp_t e;
    mx_m  = satv(mx_m + stepv(xs, xm));
    my_m  = satv(my_m + stepv(ys, ym));
    btn_m = b;
    e.due  = cyc + 3;
    e.ax   = 8'(mx_m);
    e.ay   = 8'(my_m);
    e.j0   = {bus.joy_0[7], btn_m, bus.joy_0[4:0]};
    e.mode = 1'b1;
    sb.push_back(e);
  endtask

  task automatic send_pkt(bit xs, logic [7:0] xm, bit ys, logic [7:0] ym,
                          logic [1:0] b, bit expect_it);
    logic [24:0] v;
    v = '0;
    v[24]    = ~bus.ps2_mouse[24];
    v[23:16] = ym;
    v[15:8]  = xm;
    v[5]     = ys;
    v[4]     = xs;
    v[1:0]   = b;
    bus.ps2_mouse = v;
    if (expect_it) model_packet(xs, xm, ys, ym, b);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    mx_m = 0;
    my_m = 0;
    btn_m = 2'b00;
  endtask

  task automatic test_reset();
    bus.ps2_mouse = '0;
    bus.joya_0 = '0;
    bus.joy_0 = '0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    // packet in flight when reset hits must be discarded
    send_pkt(1'b0, 8'h14, 1'b0, 8'h14, 2'b11, 1'b0);
    tick();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_pkt(1'b0, 8'h14, 1'b0, 8'h14, 2'b11, 1'b0);
      tick();
    end
    n_tests++;
    if ({bus.ax, bus.ay, bus.j0, bus.mouse_mode} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_hold: ax=%h ay=%h j0=%h mode=%b, required all 0",
               bus.ax, bus.ay, bus.j0, bus.mouse_mode);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if ({bus.ax, bus.ay, bus.j0, bus.mouse_mode} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_release: ax=%h ay=%h j0=%h mode=%b, required all 0",
               bus.ax, bus.ay, bus.j0, bus.mouse_mode);
    end
    mx_m = 0;
    my_m = 0;
    btn_m = 2'b00;
  endtask

  task automatic test_small_move();
    exp_t e;
    do_reset();
    send_pkt(1'b0, 8'h0C, 1'b0, 8'h00, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) begin
        n_tests++;
        if (bus.mouse_mode !== 1'b0 || bus.ax !== 8'h00) begin
          n_fail++;
          $display("FAIL small_early: ax=%h mode=%b, required ax=00 mode=0",
                   bus.ax, bus.mouse_mode);
        end
      end
      while (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        n_tests++;
        if ({bus.ax, bus.ay, bus.j0, bus.mouse_mode} !== {e.ax, e.ay, e.j0, e.mode}) begin
          n_fail++;
          $display("FAIL small_move cyc=%0d: ax=%h ay=%h j0=%h mode=%b, required ax=%h ay=%h j0=%h mode=%b",
                   cyc, bus.ax, bus.ay, bus.j0, bus.mouse_mode, e.ax, e.ay, e.j0, e.mode);
        end
      end
    end
  endtask

  task automatic test_negative_clamp();
    exp_t e;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      if (p == 0) send_pkt(1'b1, 8'hF0, 1'b0, 8'h00, 2'b00, 1'b1);
      else        send_pkt(1'b0, 8'h7E, 1'b0, 8'h00, 2'b00, 1'b1);
      for (int i = 0; i < 3; i++) begin
        tick();
        while (sb.size() > 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          n_tests++;
          if ({bus.ax, bus.ay, bus.j0, bus.mouse_mode} !== {e.ax, e.ay, e.j0, e.mode}) begin
            n_fail++;
            $display("FAIL neg_clamp cyc=%0d: ax=%h ay=%h j0=%h mode=%b, required ax=%h ay=%h j0=%h mode=%b",
                     cyc, bus.ax, bus.ay, bus.j0, bus.mouse_mode, e.ax, e.ay, e.j0, e.mode);
          end
        end
      end
    end
    n_tests++;
    if (bus.ax !== 8'h02) begin
      n_fail++;
      $display("FAIL neg_clamp_final: ax=%h, required 02", bus.ax);
    end
  endtask

  task automatic test_back_to_back_saturation();
    exp_t e;
    do_reset();
    for (int i = 0; i < 47; i++) begin
      if (i < 14)      send_pkt(1'b0, 8'h00, 1'b0, 8'h7E, 2'b00, 1'b1);
      else if (i < 44) send_pkt(1'b0, 8'h00, 1'b1, 8'h80, 2'b00, 1'b1);
      tick();
      while (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        n_tests++;
        if ({bus.ax, bus.ay, bus.j0, bus.mouse_mode} !== {e.ax, e.ay, e.j0, e.mode}) begin
          n_fail++;
          $display("FAIL saturation cyc=%0d: ax=%h ay=%h j0=%h mode=%b, required ax=%h ay=%h j0=%h mode=%b",
                   cyc, bus.ax, bus.ay, bus.j0, bus.mouse_mode, e.ax, e.ay, e.j0, e.mode);
        end
      end
    end
    n_tests++;
    if (bus.ay !== 8'h80) begin
      n_fail++;
      $display("FAIL saturation_low: ay=%h, required 80", bus.ay);
    end
  endtask

  task automatic test_buttons();
    exp_t e;
    bus.joy_0 = 16'h00A5;
    do_reset();
    send_pkt(1'b0, 8'h00, 1'b0, 8'h00, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      while (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        n_tests++;
        if ({bus.ax, bus.ay, bus.j0, bus.mouse_mode} !== {e.ax, e.ay, e.j0, e.mode}) begin
          n_fail++;
          $display("FAIL buttons cyc=%0d: ax=%h ay=%h j0=%h mode=%b, required ax=%h ay=%h j0=%h mode=%b",
                   cyc, bus.ax, bus.ay, bus.j0, bus.mouse_mode, e.ax, e.ay, e.j0, e.mode);
        end
      end
    end
    bus.joya_0 = 16'h0005;
    tick();
    n_tests++;
    if ({bus.ax, bus.ay, bus.j0, bus.mouse_mode} !== {8'h05, 8'h00, 8'hA5, 1'b0}) begin
      n_fail++;
      $display("FAIL joy_takeover: ax=%h ay=%h j0=%h mode=%b, required ax=05 ay=00 j0=a5 mode=0",
               bus.ax, bus.ay, bus.j0, bus.mouse_mode);
    end
    bus.joya_0 = '0;
    mx_m = 0;
    my_m = 0;
    tick();
  endtask

  task automatic test_collision();
    exp_t e;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      // p=0 enters mouse mode at +10; p=1 proves the accumulators were cleared
      if (p == 0) send_pkt(1'b0, 8'h14, 1'b0, 8'h00, 2'b00, 1'b1);
      else        send_pkt(1'b0, 8'h02, 1'b0, 8'h00, 2'b00, 1'b1);
      for (int i = 0; i < 3; i++) begin
        tick();
        while (sb.size() > 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          n_tests++;
          if ({bus.ax, bus.ay, bus.j0, bus.mouse_mode} !== {e.ax, e.ay, e.j0, e.mode}) begin
            n_fail++;
            $display("FAIL collision cyc=%0d: ax=%h ay=%h j0=%h mode=%b, required ax=%h ay=%h j0=%h mode=%b",
                     cyc, bus.ax, bus.ay, bus.j0, bus.mouse_mode, e.ax, e.ay, e.j0, e.mode);
          end
        end
      end
      if (p == 0) begin
        send_pkt(1'b0, 8'h14, 1'b0, 8'h00, 2'b00, 1'b0);
        tick();
        bus.joya_0 = 16'h0003;
        tick();
        n_tests++;
        if ({bus.ax, bus.ay, bus.j0, bus.mouse_mode} !== {8'h03, 8'h00, bus.joy_0[7:0], 1'b0}) begin
          n_fail++;
          $display("FAIL collision_joy: ax=%h ay=%h j0=%h mode=%b, required ax=03 ay=00 j0=%h mode=0",
                   bus.ax, bus.ay, bus.j0, bus.mouse_mode, bus.joy_0[7:0]);
        end
        bus.joya_0 = '0;
        mx_m = 0;
        my_m = 0;
        tick();
        tick();
        n_tests++;
        if (bus.ax !== 8'h00 || bus.mouse_mode !== 1'b0) begin
          n_fail++;
          $display("FAIL collision_drop: ax=%h mode=%b, required ax=00 mode=0",
                   bus.ax, bus.mouse_mode);
        end
      end
    end
  endtask

  initial begin
    mx_m = 0;
    my_m = 0;
    btn_m = 2'b00;
    test_reset();
    test_small_move();
    test_negative_clamp();
    test_back_to_back_saturation();
    test_buttons();
    test_collision();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/paddle_mouse_emu.md
# paddle_mouse_emu

Converts PS/2 mouse packets into absolute paddle positions and a fire-button map for the Atari 2600 core, and arbitrates between mouse and analog-joystick sources. Sits between hps_io (ps2_mouse, joystick_analog_0, joystick_0) and the A2601top paddle_0/paddle_1/p_a/p_b inputs. Outputs are registered and drive those inputs directly.

## Interface
- STEP_LIMIT, 10, maximum magnitude of one packet's delta after scaling; signed, 1..127
- POS_MAX, 127, upper saturation bound of the accumulated position; lower bound is -(POS_MAX+1)
- clk_sys  in  1  system clock; single clock domain
- reset_n  in  1  synchronous, active-low reset
- ps2_mouse  in  25  [24] packet strobe (toggles per packet), [5] Y sign, [4] X sign, [1:0] buttons, [15:8] X move, [23:16] Y move
- joya_0  in  16  analog stick: [7:0] X, [15:8] Y, two's complement
- joy_0  in  16  digital joystick/buttons, player 1
- ax  out  8  paddle 0 position, two's complement
- ay  out  8  paddle 1 position, two's complement
- j0  out  8  button map: {joy_0[7], b1, b0, joy_0[4:0]}
- mouse_mode  out  1  1 = mouse is the active source

## Operation
- Source FSM, 2 states: JOY (reset state) and MOUSE.
  - JOY -> MOUSE: a packet is accepted.
  - MOUSE -> JOY: joya_0 != 0 in any cycle. Accumulators clear to 0 in the same cycle.
  - In JOY, joya_0 != 0 keeps the accumulators at 0.
- Packet detect: stb_q holds the previous ps2_mouse[24]. A packet is accepted when ps2_mouse[24] != stb_q. During reset, stb_q loads ps2_mouse[24], so no packet fires on reset release.
- Stage 1, on accept:
  - dx = {X sign, X sign, Xmove[7:1]} as a 9-bit signed value; dy is built the same way from the Y fields.
  - Each is clamped to ±STEP_LIMIT and registered with a valid flag.
  - ps2_mouse[1:0] is latched as btn.
- Stage 2, on valid:
  - pos = sat(pos + d) per axis, using 9-bit signed arithmetic (10-bit intermediate).
  - The result saturates to [-(POS_MAX+1), POS_MAX]. There is no wrap-around.
- Output register:
  - MOUSE: ax = mx[7:0], ay = my[7:0], j0 = {joy_0[7], btn, joy_0[4:0]}.
  - JOY: ax = joya_0[7:0], ay = joya_0[15:8], j0 = joy_0[7:0].
- Simultaneous events:
  - joya_0 != 0 in the same cycle as a stage-2 update: the joystick wins. Accumulators go to 0, the state goes to JOY, and the pending delta is dropped.
  - A new accept while stage 2 is busy is pipelined; one packet per cycle is sustained.
- Reset mid-operation: pipeline valid flags clear, accumulators, btn and state clear, and in-flight packets are discarded.

## Timing
- Reset values: ax=0, ay=0, j0=0, mouse_mode=0, mx=my=0, btn=0.
- Mouse latency: strobe toggles in cycle t; stage 1 is registered at the t edge; pos updates at t+1; ax/ay/j0/mouse_mode are valid after the t+2 edge.
- Joystick path latency: 1 cycle (registered output).
- mouse_mode is updated in the same output register as ax/ay. It rises together with the first mouse-derived position.
- The strobe may toggle every cycle; every toggle is one packet.

## Structure
- Shared package atari_input_pkg holds:
  - the src_mode_t enum {SRC_JOY, SRC_MOUSE}
  - the default STEP_LIMIT and POS_MAX localparams
  - the ps2_mouse field bit-index constants
- Sub-module sat_accum (9-bit signed saturating accumulator with clear, step clamp and bounds as parameters) is instantiated twice, once for X and once for Y.

## Test plan
- Reset: hold reset_n=0 with strobe toggling -> all outputs 0 and mouse_mode=0. After release with no toggle -> no change.
- Small move: X sign 0, Xmove=0x0C, toggle strobe -> after 3 edges ax=6, ay=0, mouse_mode=1.
- Negative and clamp:
  - X sign 1, Xmove=0xF0 -> ax=-8 (0xF8).
  - Then Xmove=0x7E with sign 0 -> delta clamps to +10 -> ax=2.
- Saturation: 14 consecutive toggles of +10 on Y -> ay=127 and stays 127. 30 toggles of -10 -> ay=-128 (0x80).
- Buttons: mouse mode with ps2_mouse[1:0]=2'b10 latched -> j0[6:5]=2'b10. Set joya_0=16'h0005 -> next cycle ax=5, mouse_mode=0, j0=joy_0[7:0].
- Collision: joya_0 goes nonzero in the cycle stage 2 would add +10 -> accumulators 0, state JOY, the +10 never appears on ax.
